// File: rtl/ex_mem_skid_reg.sv
// EX->MEM writeback register with a 2-slot skid buffer, flush, x0-write suppression and occupancy count.
// Optional performance counters are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int SIDE_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rdE,
  input  logic [IDX_W-1:0]  in_rdIdx,
  input  logic [DATA_W-1:0] in_rdData,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_rdE,
  output logic [IDX_W-1:0]  out_rdIdx,
  output logic [DATA_W-1:0] out_rdData,
  output logic [SIDE_W-1:0] out_side,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0]       bubble_cnt_out,
  output logic [31:0]       backpr_cnt_out,
`endif
  output logic [1:0]        count_out
);

  // Writes to x0 are architecturally void, so they are dropped at capture.
  function automatic logic cap_rde(input logic rde, input logic [IDX_W-1:0] idx);
    return rde && (idx != {IDX_W{1'b0}});
  endfunction

  logic              main_v_r,    main_v_s;
  logic              main_rde_r,  main_rde_s;
  logic [IDX_W-1:0]  main_idx_r,  main_idx_s;
  logic [DATA_W-1:0] main_data_r, main_data_s;
  logic [SIDE_W-1:0] main_side_r, main_side_s;
  logic              skid_v_r,    skid_v_s;
  logic              skid_rde_r,  skid_rde_s;
  logic [IDX_W-1:0]  skid_idx_r,  skid_idx_s;
  logic [DATA_W-1:0] skid_data_r, skid_data_s;
  logic [SIDE_W-1:0] skid_side_r, skid_side_s;
  logic [1:0]        count_r,     count_s;
  logic              accept_s;
  logic              consume_s;
  logic              in_rde_s;

  assign in_ready  = !skid_v_r && !flush_in;
  assign accept_s  = in_valid && in_ready;
  assign consume_s = main_v_r && out_ready;
  assign in_rde_s  = cap_rde(in_rdE, in_rdIdx);

  // Next-state selection for the main and skid slots.
  always_comb begin
    main_v_s    = main_v_r;
    main_rde_s  = main_rde_r;
    main_idx_s  = main_idx_r;
    main_data_s = main_data_r;
    main_side_s = main_side_r;
    skid_v_s    = skid_v_r;
    skid_rde_s  = skid_rde_r;
    skid_idx_s  = skid_idx_r;
    skid_data_s = skid_data_r;
    skid_side_s = skid_side_r;
    if (flush_in) begin
      main_v_s    = 1'b0;
      main_rde_s  = 1'b0;
      main_idx_s  = {IDX_W{1'b0}};
      main_data_s = {DATA_W{1'b0}};
      main_side_s = {SIDE_W{1'b0}};
      skid_v_s    = 1'b0;
      skid_rde_s  = 1'b0;
      skid_idx_s  = {IDX_W{1'b0}};
      skid_data_s = {DATA_W{1'b0}};
      skid_side_s = {SIDE_W{1'b0}};
    end else if (!main_v_r) begin
      if (accept_s) begin
        main_v_s    = 1'b1;
        main_rde_s  = in_rde_s;
        main_idx_s  = in_rdIdx;
        main_data_s = in_rdData;
        main_side_s = in_side;
      end else begin
        main_v_s    = 1'b0;
      end
    end else if (consume_s) begin
      if (skid_v_r) begin
        // Skid drains first to keep FIFO order; in_ready is low here.
        main_v_s    = 1'b1;
        main_rde_s  = skid_rde_r;
        main_idx_s  = skid_idx_r;
        main_data_s = skid_data_r;
        main_side_s = skid_side_r;
        skid_v_s    = 1'b0;
        skid_rde_s  = 1'b0;
        skid_idx_s  = {IDX_W{1'b0}};
        skid_data_s = {DATA_W{1'b0}};
        skid_side_s = {SIDE_W{1'b0}};
      end else if (accept_s) begin
        main_v_s    = 1'b1;
        main_rde_s  = in_rde_s;
        main_idx_s  = in_rdIdx;
        main_data_s = in_rdData;
        main_side_s = in_side;
      end else begin
        // Empty main presents a NOP bubble to forwarding logic.
        main_v_s    = 1'b0;
        main_rde_s  = 1'b0;
        main_idx_s  = {IDX_W{1'b0}};
        main_data_s = {DATA_W{1'b0}};
        main_side_s = {SIDE_W{1'b0}};
      end
    end else begin
      if (accept_s) begin
        skid_v_s    = 1'b1;
        skid_rde_s  = in_rde_s;
        skid_idx_s  = in_rdIdx;
        skid_data_s = in_rdData;
        skid_side_s = in_side;
      end else begin
        skid_v_s    = skid_v_r;
      end
    end
    count_s = {main_v_s & skid_v_s, main_v_s ^ skid_v_s};
  end

  // Slot storage and registered occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      main_v_r    <= 1'b0;
      main_rde_r  <= 1'b0;
      main_idx_r  <= {IDX_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      main_side_r <= {SIDE_W{1'b0}};
      skid_v_r    <= 1'b0;
      skid_rde_r  <= 1'b0;
      skid_idx_r  <= {IDX_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      skid_side_r <= {SIDE_W{1'b0}};
      count_r     <= 2'd0;
    end else begin
      main_v_r    <= main_v_s;
      main_rde_r  <= main_rde_s;
      main_idx_r  <= main_idx_s;
      main_data_r <= main_data_s;
      main_side_r <= main_side_s;
      skid_v_r    <= skid_v_s;
      skid_rde_r  <= skid_rde_s;
      skid_idx_r  <= skid_idx_s;
      skid_data_r <= skid_data_s;
      skid_side_r <= skid_side_s;
      count_r     <= count_s;
    end
  end

  assign out_valid  = main_v_r;
  assign out_rdE    = main_rde_r;
  assign out_rdIdx  = main_idx_r;
  assign out_rdData = main_data_r;
  assign out_side   = main_side_r;
  assign count_out  = count_r;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] backpr_cnt_r;

  // Counters survive flush; they only observe the MEM-side handshake.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bubble_cnt_r <= 32'd0;
      backpr_cnt_r <= 32'd0;
    end else begin
      if (!main_v_r) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      if (main_v_r && !out_ready) begin
        backpr_cnt_r <= backpr_cnt_r + 32'd1;
      end else begin
        backpr_cnt_r <= backpr_cnt_r;
      end
    end
  end

  assign bubble_cnt_out = bubble_cnt_r;
  assign backpr_cnt_out = backpr_cnt_r;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Table-driven bench for ex_mem_skid_reg plus hand-written reset sequences.
module tb_ex_mem_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_rde;
  logic [4:0]  in_idx;
  logic [31:0] in_data;
  logic [7:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic        out_rde;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic [7:0]  out_side;
  logic [1:0]  count;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] backpr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ex_mem_skid_reg dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .flush_in   (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rdE     (in_rde),
    .in_rdIdx   (in_idx),
    .in_rdData  (in_data),
    .in_side    (in_side),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdE    (out_rde),
    .out_rdIdx  (out_idx),
    .out_rdData (out_data),
    .out_side   (out_side),
`ifdef EX_MEM_PERF_CNT_EN
    .bubble_cnt_out (bubble_cnt),
    .backpr_cnt_out (backpr_cnt),
`endif
    .count_out  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rde;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        ordy;
    logic        fl;
    logic        e_irdy;
    logic        e_ov;
    logic        e_rde;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] side_of(input logic [31:0] d);
    return d[7:0] ^ 8'hA5;
  endfunction

  task automatic add(input logic v, input logic rde, input logic [4:0] idx, input logic [31:0] data,
                     input logic ordy, input logic fl, input logic e_irdy, input logic e_ov,
                     input logic e_rde, input logic [4:0] e_idx, input logic [31:0] e_data,
                     input logic [1:0] e_cnt);
    vec_t t;
    t.v = v; t.rde = rde; t.idx = idx; t.data = data; t.ordy = ordy; t.fl = fl;
    t.e_irdy = e_irdy; t.e_ov = e_ov; t.e_rde = e_rde; t.e_idx = e_idx;
    t.e_data = e_data; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rde, input logic [4:0] idx, input logic [31:0] data,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_rde    = rde;
    in_idx    = idx;
    in_data   = data;
    in_side   = side_of(data);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".out_rdE"},   {31'd0, out_rde},   32'd0);
    chk({tag, ".out_rdIdx"}, {27'd0, out_idx},   32'd0);
    chk({tag, ".out_rdData"}, out_data,          32'd0);
    chk({tag, ".out_side"},  {24'd0, out_side},  32'd0);
    chk({tag, ".count"},     {30'd0, count},     32'd0);
  endtask

  initial begin
    // reset check while EX is presenting
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_empty("reset");
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst_n = 1'b1;

    // first accept after reset
    add(1, 1, 5'd3, 32'hDEADBEEF, 1, 0,  1, 1, 1, 5'd3, 32'hDEADBEEF, 2'd1);
    // streaming, one entry per cycle
    for (int k = 1; k <= 8; k++)
      add(1, 1, 5'(k), 32'h10 + 32'(k - 1), 1, 0,  1, 1, 1, 5'(k), 32'h10 + 32'(k - 1), 2'd1);
    add(0, 0, 5'd0, 32'h0, 1, 0,  1, 0, 0, 5'd0, 32'h0, 2'd0);
    // backpressure: fill both slots, then drain in order
    add(1, 1, 5'd4, 32'h44, 0, 0,  1, 1, 1, 5'd4, 32'h44, 2'd1);
    add(1, 1, 5'd5, 32'h45, 0, 0,  1, 1, 1, 5'd4, 32'h44, 2'd2);
    add(1, 1, 5'd6, 32'h46, 0, 0,  0, 1, 1, 5'd4, 32'h44, 2'd2);
    add(0, 0, 5'd0, 32'h0,  1, 0,  0, 1, 1, 5'd5, 32'h45, 2'd1);
    add(0, 0, 5'd0, 32'h0,  1, 0,  1, 0, 0, 5'd0, 32'h0,  2'd0);
    // x0 write suppression, then rdE=0 on a real index
    add(1, 1, 5'd0, 32'h55, 0, 0,  1, 1, 0, 5'd0, 32'h55, 2'd1);
    add(1, 0, 5'd7, 32'h77, 1, 0,  1, 1, 0, 5'd7, 32'h77, 2'd1);
    add(1, 1, 5'd9, 32'h99, 0, 0,  1, 1, 0, 5'd7, 32'h77, 2'd2);
    // flush with two held and a concurrent input and consume
    add(1, 1, 5'd10, 32'hAA, 1, 1,  0, 0, 0, 5'd0, 32'h0, 2'd0);
    add(0, 0, 5'd0, 32'h0,   1, 0,  1, 0, 0, 5'd0, 32'h0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rde, vecs[i].idx, vecs[i].data, vecs[i].ordy, vecs[i].fl);
      #1;
      chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_irdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d.out_rdE", i),   {31'd0, out_rde},   {31'd0, vecs[i].e_rde});
      chk($sformatf("v%0d.out_rdIdx", i), {27'd0, out_idx},   {27'd0, vecs[i].e_idx});
      chk($sformatf("v%0d.count", i),     {30'd0, count},     {30'd0, vecs[i].e_cnt});
      if (vecs[i].e_ov || vecs[i].fl) begin
        chk($sformatf("v%0d.out_rdData", i), out_data, vecs[i].e_data);
        chk($sformatf("v%0d.out_side", i), {24'd0, out_side},
            {24'd0, (vecs[i].e_ov ? side_of(vecs[i].e_data) : 8'h00)});
      end
    end

    // asynchronous reset while stalled with two entries
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd11, 32'hB1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd12, 32'hB2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("stall.count", {30'd0, count}, 32'd2);
    chk("stall.out_rdIdx", {27'd0, out_idx}, 32'd11);
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("async_rst");
    chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst.count", {30'd0, count}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd13, 32'hC3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst.new_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst.new_idx", {27'd0, out_idx}, 32'd13);
    chk("post_rst.new_data", out_data, 32'hC3);
    chk("post_rst.new_count", {30'd0, count}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
